// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and sizing helpers for param_sync_fifo.
// Read-mode encodings and pointer/count width functions.
package param_sync_fifo_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  // One extra MSB lets equal indices mean either full or empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and
// one combinational read port, DATA_WIDTH x DEPTH, no reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO, standard or first-word-fall-through.
// Define PARAM_SYNC_FIFO_ERR_EN for sticky overflow/underflow flags.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 8,
  parameter int AFULL_THRESH  = DATA_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FWFT_STD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           full,
  output logic                           almost_full,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           empty,
  output logic                           almost_empty,
  output logic [cnt_w(DATA_DEPTH)-1:0]   count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = ptr_w(DATA_DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = cnt_w(DATA_DEPTH);

  localparam logic [CW-1:0] AF_C = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AEMPTY_THRESH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] count_n;
  logic          full_n;
  logic          empty_n;
  logic          wr_ok;
  logic          rd_ok;
  logic [DATA_WIDTH-1:0] ram_q;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign wr_ptr_n = wr_ptr + PW'(wr_ok);
  assign rd_ptr_n = rd_ptr + PW'(rd_ok);

  assign count_n = CW'(wr_ptr_n - rd_ptr_n);
  assign empty_n = (wr_ptr_n == rd_ptr_n);
  assign full_n  = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                   (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= (count_n >= AF_C);
      almost_empty <= (count_n <= AE_C);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DATA_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head is shown live; masked so an empty FIFO reads zero.
      assign rd_data = empty ? '0 : ram_q;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data <= '0;
        end else if (rd_ok) begin
          rd_data <= ram_q;
        end
      end
    end
  endgenerate

`ifdef PARAM_SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: standard-mode and FWFT instances of param_sync_fifo.
// Expected values are hand-derived constants and a counted occupancy.
module tb_param_sync_fifo;

`ifdef PARAM_SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       full, afull, empty, aempty, ovf, unf;
  logic [3:0] count;

  logic       f_wr_en = 1'b0;
  logic       f_rd_en = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic [7:0] f_rd_data;
  logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] tbl [8] = '{8'h3C, 8'hA7, 8'h01, 8'hFE,
                          8'h5B, 8'h90, 8'h6D, 8'hE2};

  always #5 clk = ~clk;

  param_sync_fifo u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (afull),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (aempty),
    .count        (count),
    .overflow     (ovf),
    .underflow    (unf)
  );

  param_sync_fifo #(.FWFT(1)) u_fw (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (f_wr_en),
    .wr_data      (f_wr_data),
    .full         (f_full),
    .almost_full  (f_afull),
    .rd_en        (f_rd_en),
    .rd_data      (f_rd_data),
    .empty        (f_empty),
    .almost_empty (f_aempty),
    .count        (f_count),
    .overflow     (f_ovf),
    .underflow    (f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_f_empty", 32'(f_empty), 1);
    chk("rst_f_rd_data", 32'(f_rd_data), 0);

    // fill 0 -> 8
    n = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = tbl[i];
      tick();
      n++;
      chk("fill_count", 32'(count), 32'(n));
      chk("fill_afull", 32'(afull), 32'(n >= 6));
      chk("fill_aempty", 32'(aempty), 32'(n <= 2));
      chk("fill_full", 32'(full), 32'(n == 8));
      chk("fill_empty", 32'(empty), 0);
    end

    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(ovf), 32'(ERR));
    chk("ovf_rd_data", 32'(rd_data), 0);

    // drain 8 -> 0; data proves the rejected write was dropped
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      n--;
      chk("drain_data", 32'(rd_data), 32'(tbl[i]));
      chk("drain_count", 32'(count), 32'(n));
      chk("drain_afull", 32'(afull), 32'(n >= 6));
      chk("drain_aempty", 32'(aempty), 32'(n <= 2));
      chk("drain_full", 32'(full), 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("pre_unf", 32'(unf), 0);

    tick();
    rd_en = 1'b0;
    chk("unf_flag", 32'(unf), 32'(ERR));
    chk("unf_count", 32'(count), 0);
    chk("unf_hold", 32'(rd_data), 32'(tbl[7]));
    chk("unf_ovf_sticky", 32'(ovf), 32'(ERR));

    // prime 4 entries, then stream with simultaneous read/write
    for (int k = 0; k < 4; k++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h40 + k);
      tick();
    end
    chk("prime_count", 32'(count), 4);
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 8'(8'h44 + k);
      tick();
      chk("stream_count", 32'(count), 4);
      chk("stream_data", 32'(rd_data), 32'(8'(8'h40 + k)));
    end
    rd_en   = 1'b0;
    wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_data", 32'(rd_data), 32'(8'h67));

    // reset wins over a simultaneous read and write
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rrw_count", 32'(count), 0);
    chk("rrw_empty", 32'(empty), 1);
    chk("rrw_full", 32'(full), 0);
    chk("rrw_rd_data", 32'(rd_data), 0);
    chk("rrw_ovf", 32'(ovf), 0);
    chk("rrw_unf", 32'(unf), 0);
    tick();
    chk("rrw_idle_count", 32'(count), 0);

    // first-word-fall-through instance
    f_wr_en   = 1'b1;
    f_wr_data = 8'hA5;
    tick();
    f_wr_data = 8'h5A;
    chk("fw_head", 32'(f_rd_data), 32'(8'hA5));
    chk("fw_empty", 32'(f_empty), 0);
    tick();
    f_wr_en = 1'b0;
    chk("fw_count2", 32'(f_count), 2);
    chk("fw_head_kept", 32'(f_rd_data), 32'(8'hA5));
    f_rd_en = 1'b1;
    tick();
    chk("fw_pop1", 32'(f_rd_data), 32'(8'h5A));
    chk("fw_pop1_count", 32'(f_count), 1);
    tick();
    f_rd_en = 1'b0;
    chk("fw_pop2_empty", 32'(f_empty), 1);
    chk("fw_pop2_data", 32'(f_rd_data), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one entry.
REQ-002 SHALL have parameter DATA_DEPTH, default 8: entry count; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_THRESH, default DATA_DEPTH-2: almost_full asserts when count is at or above this value.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: almost_empty asserts when count is at or below this value.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port full, output, 1 bit: count equals DATA_DEPTH.
REQ-011 SHALL have port almost_full, output, 1 bit: almost-full flag.
REQ-012 SHALL have port rd_en, input, 1 bit: read request (FWFT=1: pop).
REQ-013 SHALL have port rd_data, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port empty, output, 1 bit: count equals 0.
REQ-015 SHALL have port almost_empty, output, 1 bit: almost-empty flag.
REQ-016 SHALL have port count, output, $clog2(DATA_DEPTH)+1 bits: current occupancy.
REQ-017 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-018 SHALL accept a write when wr_en=1 and (full=0, or a read is accepted in the same cycle).
REQ-019 SHALL accept a read when rd_en=1 and empty=0; with empty=1, simultaneous rd_en and wr_en accepts the write only.
REQ-020 SHALL use read/write pointers of $clog2(DATA_DEPTH)+1 bits, wrapping modulo 2*DATA_DEPTH; the MSB distinguishes full from empty.
REQ-021 SHALL update count, full, empty, almost_full and almost_empty as registered values on the edge that accepts the access; count is unchanged when both a read and a write are accepted.
REQ-022 SHALL, with FWFT=0, register rd_data on the accepting read edge and hold it until the next accepted read.
REQ-023 SHALL, with FWFT=1, drive rd_data with the head entry whenever empty=0; rd_en pops the head and the next entry is visible the cycle after the pop.
REQ-024 SHALL ignore a rejected access: no pointer, count or memory change.
REQ-025 SHALL return data in write order with no loss across any number of pointer wrap-arounds.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, clear both pointers and set count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, overflow=0, underflow=0.
REQ-027 SHALL let rst override any access in the same cycle; the memory contents are not cleared.

Configuration
REQ-028 SHALL, with PARAM_SYNC_FIFO_ERR_EN defined, set overflow on a rejected write and underflow on a rejected read, holding each until rst.
REQ-029 SHALL, without PARAM_SYNC_FIFO_ERR_EN, tie overflow and underflow to 0 and keep both ports present.

Structure
REQ-030 SHALL place the pointer-width and count-width helper functions and the FWFT mode constants in package param_sync_fifo_pkg.
REQ-031 SHALL instantiate sub-module sync_fifo_ram, a simple dual-port array (one write port, one read port) sized DATA_WIDTH by DATA_DEPTH.

Verification
REQ-032 SHALL cover: defaults, FWFT=0; write 8 random bytes -> full=1 and count=8 after the 8th edge; a 9th write with ERR_EN -> overflow=1 and the data is unchanged.
REQ-033 SHALL cover: read 8 from full -> the same bytes in order, each 1 cycle after its rd_en edge; empty=1 after the 8th; a 9th read -> underflow=1.
REQ-034 SHALL cover: 40 cycles of simultaneous read and write at count=4 -> count stays 4, the output equals the input delayed by 4 accepted writes, and pointers wrap at least twice.
REQ-035 SHALL cover: with thresholds 6 and 2, fill 0->8 and drain 8->0 -> almost_full asserts at count 6 and almost_empty deasserts at count 3.
REQ-036 SHALL cover: FWFT=1; write 0xA5 into an empty FIFO -> rd_data=0xA5 and empty=0 the cycle after the write, with no rd_en.
REQ-037 SHALL cover: rst=1 asserted at count=5 during a simultaneous read and write -> the next cycle shows count=0, empty=1 and no data change.
